txt_arb: RTL and testbench

Text-page memory arbiter between the video fetch path and the CPU. It owns the single-port, synchronous-read 1 KiB text RAM holding the 40x24 page at $400-$7FF, including the screen holes. It sequences every access through a fixed three-cycle FSM. It serves the video character fetcher, which has priority, and CPU reads and writes over one request/ack handshake per port.

---
 rtl/txt_arb.sv | 162 ++++++++++++++++
 tb/tb_txt_arb.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txt_arb.sv
// Text-page RAM arbiter: serialises video fetches and CPU accesses through an IDLE/ADDR/DATA sequence.
// Optional macro TXT_ARB_FAIR_EN bounds how long video can hold off a waiting CPU.
module txt_arb #(
   parameter logic [15:0] BASE        = 16'h0400,
   parameter int          MAX_VID_RUN = 7
) (
   input  logic        clk,
   input  logic        res,
   input  logic        vid_req,
   input  logic [15:0] vid_adr,
   output logic [7:0]  vid_q,
   output logic        vid_ack,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_adr,
   input  logic [7:0]  cpu_d,
   output logic [7:0]  cpu_q,
   output logic        cpu_ack,
   output logic [9:0]  ram_adr,
   output logic [7:0]  ram_d,
   output logic        ram_we,
   input  logic [7:0]  ram_q
);

   // The run counter is 3 bits wide, so the limit must fit in it.
   if (MAX_VID_RUN < 1 || MAX_VID_RUN > 7) begin : g_bad_run
      $error("txt_arb: MAX_VID_RUN must be in 1..7");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA
   } state_t;

   localparam logic [7:0] VID_BLANK = 8'hA0;
   localparam logic [7:0] CPU_BLANK = 8'h00;

   function automatic logic in_window(input logic [15:0] adr);
      logic [15:0] off;
      off = adr - BASE;
      return (adr >= BASE) && (off[15:10] == 6'd0);
   endfunction

   function automatic logic [9:0] word_of(input logic [15:0] adr);
      logic [15:0] off;
      off = adr - BASE;
      return off[9:0];
   endfunction

   state_t      r_state;
   logic        r_gnt_cpu;
   logic        r_inwin;
   logic        r_wr;
   logic        r_vid_ack;
   logic        r_cpu_ack;
   logic [7:0]  r_vid_q;
   logic [7:0]  r_cpu_q;
   logic [9:0]  r_ram_adr;
   logic [7:0]  r_ram_d;
   logic        r_ram_we;

   logic        w_pick_cpu;
   logic        w_vid_win;
   logic        w_cpu_win;

   assign w_vid_win = in_window(vid_adr);
   assign w_cpu_win = in_window(cpu_adr);

`ifdef TXT_ARB_FAIR_EN
   logic [2:0]  r_run;
   logic        w_run_full;

   // Once video has won MAX_VID_RUN grants in a row against a waiting CPU, the CPU goes next.
   assign w_run_full = (r_run == 3'(MAX_VID_RUN));
   assign w_pick_cpu = cpu_req && (!vid_req || w_run_full);

   always_ff @(posedge clk) begin
      if (res) begin
         r_run <= 3'd0;
      end else if (r_state == S_IDLE && (vid_req || cpu_req)) begin
         if (w_pick_cpu) begin
            r_run <= 3'd0;
         end else if (cpu_req) begin
            r_run <= r_run + 3'd1;
         end
      end
   end
`else
   assign w_pick_cpu = cpu_req && !vid_req;
`endif

   always_ff @(posedge clk) begin
      if (res) begin
         r_state   <= S_IDLE;
         r_gnt_cpu <= 1'b0;
         r_inwin   <= 1'b0;
         r_wr      <= 1'b0;
         r_vid_ack <= 1'b0;
         r_cpu_ack <= 1'b0;
         r_vid_q   <= 8'h00;
         r_cpu_q   <= 8'h00;
         r_ram_adr <= 10'd0;
         r_ram_d   <= 8'h00;
         r_ram_we  <= 1'b0;
      end else begin
         r_vid_ack <= 1'b0;
         r_cpu_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (vid_req || cpu_req) begin
                  r_gnt_cpu <= w_pick_cpu;
                  if (w_pick_cpu) begin
                     r_ram_adr <= word_of(cpu_adr);
                     r_ram_d   <= cpu_d;
                     r_ram_we  <= cpu_we && w_cpu_win;
                     r_inwin   <= w_cpu_win;
                     r_wr      <= cpu_we;
                  end else begin
                     r_ram_adr <= word_of(vid_adr);
                     r_ram_we  <= 1'b0;
                     r_inwin   <= w_vid_win;
                     r_wr      <= 1'b0;
                  end
                  r_state <= S_ADDR;
               end
            end
            S_ADDR: begin
               // RAM samples address (and write) during this cycle; read data appears in DATA.
               r_ram_we <= 1'b0;
               r_state  <= S_DATA;
            end
            S_DATA: begin
               if (r_gnt_cpu) begin
                  r_cpu_ack <= 1'b1;
                  if (!r_wr) begin
                     r_cpu_q <= r_inwin ? ram_q : CPU_BLANK;
                  end
               end else begin
                  r_vid_ack <= 1'b1;
                  r_vid_q   <= r_inwin ? ram_q : VID_BLANK;
               end
               r_ram_we <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_ram_we <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign vid_q   = r_vid_q;
   assign vid_ack = r_vid_ack;
   assign cpu_q   = r_cpu_q;
   assign cpu_ack = r_cpu_ack;
   assign ram_adr = r_ram_adr;
   assign ram_d   = r_ram_d;
   assign ram_we  = r_ram_we;

endmodule

// File: tb/tb_txt_arb.sv
// Bench for txt_arb: attached 1 KiB sync RAM, directed vector table, corner sequences, random traffic vs a model.
module tb_txt_arb;

   logic        clk = 1'b0;
   logic        res;
   logic        vid_req;
   logic [15:0] vid_adr;
   logic [7:0]  vid_q;
   logic        vid_ack;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_adr;
   logic [7:0]  cpu_d;
   logic [7:0]  cpu_q;
   logic        cpu_ack;
   logic [9:0]  ram_adr;
   logic [7:0]  ram_d;
   logic        ram_we;
   logic [7:0]  ram_q;

   always #5 clk = ~clk;

   txt_arb dut (
      .clk(clk), .res(res),
      .vid_req(vid_req), .vid_adr(vid_adr), .vid_q(vid_q), .vid_ack(vid_ack),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_d(cpu_d),
      .cpu_q(cpu_q), .cpu_ack(cpu_ack),
      .ram_adr(ram_adr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
   );

   function automatic logic [7:0] init_val(input int i);
      return 8'(i) ^ 8'h3C;
   endfunction

   // Single-port synchronous-read RAM attached to the arbiter.
   logic [7:0] ram [0:1023];
   logic       ram_init;
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
         ram_q <= 8'h00;
      end else begin
         if (ram_we) ram[ram_adr] <= ram_d;
         ram_q <= ram[ram_adr];
      end
   end

   // Expected page contents, maintained only from the bench's own knowledge of writes.
   logic [7:0] m_mem [0:1023];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic bit win(input logic [15:0] adr);
      return adr >= 16'h0400 && adr <= 16'h07FF;
   endfunction

   function automatic logic [7:0] exp_rd(input logic [15:0] adr, input bit is_vid);
      logic [15:0] off;
      off = adr - 16'h0400;
      if (win(adr)) return m_mem[off[9:0]];
      return is_vid ? 8'hA0 : 8'h00;
   endfunction

   function automatic logic [15:0] pick_adr();
      case ($urandom_range(0, 9))
         0: return 16'h03FF;
         1: return 16'h0800;
         2: return 16'($urandom);
         3: return 16'h07FF;
         default: return 16'h0400 + 16'($urandom_range(0, 31));
      endcase
   endfunction

   // Starts at a negedge; returns at the negedge where the ack was seen (or the bound expired).
   task automatic do_access(input bit is_cpu, input bit we, input logic [15:0] adr,
                            input logic [7:0] d, output logic [7:0] q, output int lat,
                            output int nwe, output logic [9:0] wadr, output bit ok);
      q = 8'h00; lat = 0; nwe = 0; wadr = 10'd0; ok = 1'b0;
      if (is_cpu) begin
         cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_d = d;
      end else begin
         vid_req = 1'b1; vid_adr = adr;
      end
      while (lat < 20 && !ok) begin
         @(negedge clk);
         lat++;
         if (ram_we) begin nwe++; wadr = ram_adr; end
         if (is_cpu ? cpu_ack : vid_ack) begin
            ok = 1'b1;
            q = is_cpu ? cpu_q : vid_q;
         end
      end
      cpu_req = 1'b0;
      vid_req = 1'b0;
   endtask

   typedef struct {
      bit          is_cpu;
      bit          we;
      logic [15:0] adr;
      logic [7:0]  d;
      logic [7:0]  exp_q;
      int          exp_we;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [7:0]  q;
      logic [9:0]  wadr;
      logic [15:0] off;
      int          lat, nwe, vat, cat, nv, mm, vw, cw, iw, nwe_obs;
      bit          ok, cseen, vp, cp, cwe;
      logic [7:0]  vq, cq, cd, exp_cq;
      logic [15:0] va, ca;

      tbl[0]  = '{1, 1, 16'h0405, 8'hC1, 8'h00, 1};
      tbl[1]  = '{1, 0, 16'h0405, 8'h00, 8'hC1, 0};
      tbl[2]  = '{1, 1, 16'h0800, 8'hAA, 8'hC1, 0};
      tbl[3]  = '{0, 0, 16'h03FF, 8'h00, 8'hA0, 0};
      tbl[4]  = '{1, 0, 16'h0400, 8'h00, 8'h3C, 0};
      tbl[5]  = '{0, 0, 16'h0405, 8'h00, 8'hC1, 0};
      tbl[6]  = '{1, 0, 16'h03FF, 8'h00, 8'h00, 0};
      tbl[7]  = '{1, 1, 16'h07FF, 8'h5A, 8'h00, 1};
      tbl[8]  = '{0, 0, 16'h07FF, 8'h00, 8'h5A, 0};
      tbl[9]  = '{0, 0, 16'h0800, 8'h00, 8'hA0, 0};
      tbl[10] = '{1, 0, 16'hFFFF, 8'h00, 8'h00, 0};

      res = 1'b1; ram_init = 1'b1;
      vid_req = 1'b0; vid_adr = 16'h0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = 16'h0; cpu_d = 8'h0;
      for (int i = 0; i < 1024; i++) m_mem[i] = init_val(i);
      repeat (3) @(posedge clk);
      @(negedge clk);
      res = 1'b0; ram_init = 1'b0;
      chk("rst_vid_ack", vid_ack, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_vid_q", vid_q, 0);
      chk("rst_cpu_q", cpu_q, 0);
      chk("rst_ram_adr", ram_adr, 0);
      chk("rst_ram_d", ram_d, 0);
      chk("rst_ram_we", ram_we, 0);

      // Directed single accesses
      for (int i = 0; i < 11; i++) begin
         do_access(tbl[i].is_cpu, tbl[i].we, tbl[i].adr, tbl[i].d, q, lat, nwe, wadr, ok);
         chk($sformatf("tbl%0d_latency", i), lat, 3);
         chk($sformatf("tbl%0d_q", i), q, tbl[i].exp_q);
         chk($sformatf("tbl%0d_we_cycles", i), nwe, tbl[i].exp_we);
         if (tbl[i].exp_we != 0) begin
            off = tbl[i].adr - 16'h0400;
            chk($sformatf("tbl%0d_we_adr", i), wadr, off[9:0]);
         end
         if (tbl[i].is_cpu && tbl[i].we && win(tbl[i].adr)) begin
            off = tbl[i].adr - 16'h0400;
            m_mem[off[9:0]] = tbl[i].d;
         end
      end

      // Simultaneous requests: video wins, CPU follows one access later
      vid_req = 1'b1; vid_adr = 16'h0400;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h07FF;
      vat = 0; cat = 0; vq = 8'h00; cq = 8'h00;
      for (int t = 1; t <= 20 && cat == 0; t++) begin
         @(negedge clk);
         if (vid_ack) begin vat = t; vq = vid_q; vid_req = 1'b0; end
         if (cpu_ack) begin cat = t; cq = cpu_q; cpu_req = 1'b0; end
      end
      vid_req = 1'b0; cpu_req = 1'b0;
      chk("simul_vid_ack_cycle", vat, 3);
      chk("simul_cpu_ack_cycle", cat, 6);
      chk("simul_vid_q", vq, m_mem[10'h000]);
      chk("simul_cpu_q", cq, m_mem[10'h3FF]);

      // Address changes mid-access: latched address is used
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0410;
      @(negedge clk);
      cpu_adr = 16'h0420;
      ok = 1'b0; q = 8'h00;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (cpu_ack) begin ok = 1'b1; q = cpu_q; end
      end
      cpu_req = 1'b0;
      chk("midchg_ack_seen", ok, 1);
      chk("midchg_cpu_q", q, m_mem[10'h010]);

      // Reset during ADDR of a CPU read
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0430;
      @(negedge clk);
      res = 1'b1; cpu_req = 1'b0;
      @(negedge clk);
      res = 1'b0;
      chk("midrst_cpu_ack", cpu_ack, 0);
      chk("midrst_ram_we", ram_we, 0);
      chk("midrst_ram_adr", ram_adr, 0);
      chk("midrst_ram_d", ram_d, 0);
      chk("midrst_cpu_q", cpu_q, 0);
      chk("midrst_vid_q", vid_q, 0);
      nv = 0;
      repeat (5) begin
         @(negedge clk);
         if (cpu_ack || vid_ack) nv++;
      end
      chk("midrst_no_late_ack", nv, 0);
      do_access(1, 0, 16'h0430, 8'h00, q, lat, nwe, wadr, ok);
      chk("postrst_latency", lat, 3);
      chk("postrst_cpu_q", q, m_mem[10'h030]);

      // Video held continuously while the CPU waits
      vid_req = 1'b1; vid_adr = 16'h0400;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0411;
      nv = 0; cseen = 1'b0; cq = 8'h00;
      for (int t = 0; t < 60 && !cseen; t++) begin
         @(negedge clk);
         if (vid_ack) nv++;
         if (cpu_ack) begin cseen = 1'b1; cq = cpu_q; end
      end
`ifdef TXT_ARB_FAIR_EN
      vid_req = 1'b0; cpu_req = 1'b0;
      chk("fair_cpu_ack_seen", cseen, 1);
      chk("fair_vid_acks_before_cpu", nv, 7);
      chk("fair_cpu_q", cq, m_mem[10'h011]);
      repeat (4) @(negedge clk);
`else
      chk("strict_cpu_starved", cseen, 0);
      vid_req = 1'b0;
      for (int t = 0; t < 12 && !cseen; t++) begin
         @(negedge clk);
         if (cpu_ack) begin cseen = 1'b1; cq = cpu_q; end
      end
      cpu_req = 1'b0;
      chk("strict_cpu_ack_after_release", cseen, 1);
      chk("strict_cpu_q", cq, m_mem[10'h011]);
      @(negedge clk);
`endif

      // Random traffic against the transaction-level model
      vp = 1'b0; cp = 1'b0; vw = 0; cw = 0; iw = 0; nwe_obs = 0;
      va = 16'h0; ca = 16'h0; cwe = 1'b0; cd = 8'h0;
      exp_cq = m_mem[10'h011];
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (ram_we) nwe_obs++;
         if (vid_ack) begin
            chk("rnd_vid_ack_pending", vp, 1);
            if (vp) chk($sformatf("rnd_vid_q@%0h", va), vid_q, exp_rd(va, 1));
            vp = 1'b0; vid_req = 1'b0;
         end
         if (cpu_ack) begin
            chk("rnd_cpu_ack_pending", cp, 1);
            if (cp) begin
               if (!cwe) exp_cq = exp_rd(ca, 0);
               chk($sformatf("rnd_cpu_q@%0h_we%0d", ca, cwe), cpu_q, exp_cq);
               if (cwe && win(ca)) begin
                  off = ca - 16'h0400;
                  m_mem[off[9:0]] = cd;
                  iw++;
               end
            end
            cp = 1'b0; cpu_req = 1'b0;
         end
         if (vp) begin
            vw++;
            if (vw > 30) begin
               errors++;
               $display("FAIL rnd_vid_timeout waited=%0d limit=30", vw);
               vp = 1'b0; vid_req = 1'b0;
            end
         end
         if (cp) begin
            cw++;
            if (cw > 30) begin
               errors++;
               $display("FAIL rnd_cpu_timeout waited=%0d limit=30", cw);
               cp = 1'b0; cpu_req = 1'b0;
            end
         end
         if (n < 560) begin
            if (!vp && $urandom_range(0, 2) == 0) begin
               vp = 1'b1; vw = 0; va = pick_adr();
               vid_adr = va; vid_req = 1'b1;
            end
            if (!cp && $urandom_range(0, 2) == 0) begin
               cp = 1'b1; cw = 0; ca = pick_adr();
               cwe = ($urandom_range(0, 2) == 0); cd = 8'($urandom);
               cpu_adr = ca; cpu_we = cwe; cpu_d = cd; cpu_req = 1'b1;
            end
         end
      end
      chk("rnd_drained", {30'd0, vp, cp}, 0);
      chk("rnd_we_cycles", nwe_obs, iw);

      mm = 0;
      for (int i = 0; i < 1024; i++) if (ram[i] !== m_mem[i]) mm++;
      chk("ram_contents_diffs", mm, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
